// File: rtl/md_phase_sequencer.sv
// Timestep sequencer: drives the phase-1/phase-2 READY/DONE handshake, flips the
// position/velocity double buffer per completed step, and guards each handshake with a watchdog.
module md_phase_sequencer #(
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned TIMEOUT = 1048576,
  parameter int unsigned TO_W    = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] n_steps,
  output logic              p1_ready,
  input  logic              p1_done,
  output logic              p2_ready,
  input  logic              p2_done,
  output logic              double_buffer,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count,
  output logic              timeout_err,
  output logic [1:0]        err_phase
);

  typedef enum logic [2:0] {
    S_IDLE, S_P1_REQ, S_P1_REL, S_P2_REQ, S_P2_REL, S_SWAP, S_FINISH, S_ERROR
  } state_t;

  // Last count value before expiry: the error fires on the edge the counter would reach TIMEOUT.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [TO_W-1:0]   wd_cnt;
  logic [STEP_W-1:0] target;
  logic              accept;
  logic              wd_fire;
  logic              in_handshake;

  assign in_handshake = (state == S_P1_REQ) || (state == S_P1_REL) ||
                        (state == S_P2_REQ) || (state == S_P2_REL);
  assign wd_fire      = (TIMEOUT != 0) && in_handshake && (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (n_steps == '0) ? S_FINISH : S_P1_REQ;
        end
      end
      S_P1_REQ: begin
        if (wd_fire)      state_nxt = S_ERROR;
        else if (p1_done) state_nxt = S_P1_REL;
      end
      S_P1_REL: begin
        if (wd_fire)       state_nxt = S_ERROR;
        else if (!p1_done) state_nxt = S_P2_REQ;
      end
      S_P2_REQ: begin
        if (wd_fire)      state_nxt = S_ERROR;
        else if (p2_done) state_nxt = S_P2_REL;
      end
      S_P2_REL: begin
        if (wd_fire)       state_nxt = S_ERROR;
        else if (!p2_done) state_nxt = S_SWAP;
      end
      S_SWAP:   state_nxt = (step_count + STEP_W'(1) == target) ? S_FINISH : S_P1_REQ;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      wd_cnt        <= '0;
      target        <= '0;
      p1_ready      <= 1'b0;
      p2_ready      <= 1'b0;
      double_buffer <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      step_count    <= '0;
      timeout_err   <= 1'b0;
      err_phase     <= '0;
    end else begin
      state <= state_nxt;
      // READY/busy are registered copies of the next-state decode, so they track state exactly.
      p1_ready <= (state_nxt == S_P1_REQ);
      p2_ready <= (state_nxt == S_P2_REQ);
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
      done     <= (state == S_FINISH) && !abort;

      if (state_nxt != state)  wd_cnt <= '0;
      else if (in_handshake)   wd_cnt <= wd_cnt + TO_W'(1);

      if (accept) begin
        target      <= n_steps;
        step_count  <= '0;
        timeout_err <= 1'b0;
        err_phase   <= '0;
      end else if (state == S_SWAP && !abort) begin
        step_count    <= step_count + STEP_W'(1);
        double_buffer <= ~double_buffer;
      end

      if (state_nxt == S_ERROR && state != S_ERROR) begin
        timeout_err <= 1'b1;
        err_phase   <= (state == S_P1_REQ || state == S_P1_REL) ? 2'd1 : 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_md_phase_sequencer.sv
// Bench for md_phase_sequencer: reactive phase-engine models plus a cycle-arithmetic
// reference for run length, READY ordering, buffer flips and watchdog timing.
module tb_md_phase_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] n_steps;
  logic        p1_ready, p1_done, p2_ready, p2_done;
  logic        double_buffer, busy, done, timeout_err;
  logic [15:0] step_count;
  logic [1:0]  err_phase;

  md_phase_sequencer #(.STEP_W(16), .TIMEOUT(16), .TO_W(21)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .n_steps(n_steps),
    .p1_ready(p1_ready), .p1_done(p1_done), .p2_ready(p2_ready), .p2_done(p2_done),
    .double_buffer(double_buffer), .busy(busy), .done(done), .step_count(step_count),
    .timeout_err(timeout_err), .err_phase(err_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Engine configuration: DONE rises after d cycles of READY, falls h cycles after READY drops.
  int cfg_d1 = 5, cfg_h1 = 1, cfg_d2 = 5, cfg_h2 = 1;
  bit never1 = 0, never2 = 0;

  // Monitor logs, stamped with the cycle index.
  int cyc = 0;
  int seq_q[$];
  int w1_q[$];
  int w2_q[$];
  int gap_q[$];
  int done_q[$];
  int db_q[$];
  int both_hi = 0;
  int exp_db  = 0;

  initial begin
    int c1, c2, f1c, f2c, r1, r2, fall1;
    bit p1_q, p2_q, db_prev;
    c1 = 0; c2 = 0; f1c = 0; f2c = 0; r1 = 0; r2 = 0; fall1 = 0;
    p1_q = 0; p2_q = 0; db_prev = 0;
    p1_done = 1'b0;
    p2_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (p1_ready && !p1_q) begin seq_q.push_back(1); r1 = cyc; end
      if (!p1_ready && p1_q) begin w1_q.push_back(cyc - r1); fall1 = cyc; end
      if (p2_ready && !p2_q) begin seq_q.push_back(2); r2 = cyc; gap_q.push_back(cyc - fall1); end
      if (!p2_ready && p2_q) w2_q.push_back(cyc - r2);
      if (done) done_q.push_back(cyc);
      if (double_buffer != db_prev) db_q.push_back(int'(double_buffer));
      if (p1_ready && p2_ready) both_hi++;
      p1_q = p1_ready; p2_q = p2_ready; db_prev = double_buffer;

      if (p1_ready) begin
        c1++; f1c = 0;
        if (c1 == cfg_d1 && !never1) p1_done = 1'b1;
      end else begin
        c1 = 0;
        if (p1_done) begin f1c++; if (f1c >= cfg_h1) begin p1_done = 1'b0; f1c = 0; end end
      end
      if (p2_ready) begin
        c2++; f2c = 0;
        if (c2 == cfg_d2 && !never2) p2_done = 1'b1;
      end else begin
        c2 = 0;
        if (p2_done) begin f2c++; if (f2c >= cfg_h2) begin p2_done = 1'b0; f2c = 0; end end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int outs_packed();
    return int'({p1_ready, p2_ready, double_buffer, busy, done, timeout_err, err_phase, step_count});
  endfunction

  task automatic clear_logs();
    seq_q.delete(); w1_q.delete(); w2_q.delete(); gap_q.delete();
    done_q.delete(); db_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_db = 0;
    repeat (15) step();
  endtask

  // Full run: each step lasts d1+h1+d2+h2+1 cycles, and done lands 2 cycles past the last step.
  task automatic run_steps(input int n, input int d1, input int h1, input int d2, input int h2);
    int s, len, lim;
    cfg_d1 = d1; cfg_h1 = h1; cfg_d2 = d2; cfg_h2 = h2;
    clear_logs();
    n_steps = 16'(n);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    check_eq("err_cleared", int'({timeout_err, err_phase}), 0);
    len = d1 + h1 + d2 + h2 + 1;
    lim = n * len + 20;
    for (int i = 0; i < lim && done_q.size() == 0; i++) step();
    step(); step();
    check_eq("done_count", done_q.size(), 1);
    if (done_q.size() > 0) check_eq("done_cycle", done_q[0] - s, n * len + 2);
    check_eq("ready_rises", seq_q.size(), 2 * n);
    for (int i = 0; i < seq_q.size(); i++) check_eq("ready_order", seq_q[i], (i % 2) + 1);
    foreach (w1_q[i]) check_eq("p1_width", w1_q[i], d1);
    foreach (w2_q[i]) check_eq("p2_width", w2_q[i], d2);
    foreach (gap_q[i]) check_eq("p1_to_p2_gap", gap_q[i], h1);
    check_eq("db_flips", db_q.size(), n);
    foreach (db_q[i]) check_eq("db_value", db_q[i], exp_db ^ ((i + 1) % 2));
    exp_db = exp_db ^ (n % 2);
    check_eq("step_count", int'(step_count), n);
    check_eq("db_final", int'(double_buffer), exp_db);
    check_eq("busy_after", int'(busy), 0);
    check_eq("ready_overlap", both_hi, 0);
  endtask

  // Watchdog: READY of the stuck phase stays for 16 cycles, then the sequencer lands in ERROR.
  task automatic wd_test(input int ph);
    bit seen;
    never1 = (ph == 1); never2 = (ph == 2);
    cfg_d1 = 3; cfg_h1 = 1; cfg_d2 = 3; cfg_h2 = 1;
    n_steps = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if ((ph == 1) ? p1_ready : p2_ready) seen = 1;
      else step();
    end
    check_eq("wd_ready_rise", int'(seen), 1);
    repeat (15) step();
    check_eq("wd_ready_held", int'((ph == 1) ? p1_ready : p2_ready), 1);
    step();
    check_eq("wd_ready_drop", int'({p1_ready, p2_ready}), 0);
    check_eq("wd_timeout_err", int'(timeout_err), 1);
    check_eq("wd_err_phase", int'(err_phase), ph);
    check_eq("wd_busy", int'(busy), 0);
    never1 = 0; never2 = 0;
    repeat (5) step();
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; n_steps = '0;
    repeat (3) step();
    check_eq("reset_outputs", outs_packed(), 0);
    reset = 1'b0;
    step();
    check_eq("idle_outputs", outs_packed(), 0);

    run_steps(3, 5, 1, 5, 1);
    run_steps(0, 5, 1, 5, 1);
    wd_test(2);
    run_steps(1, 3, 1, 3, 1);
    wd_test(1);
    run_steps(1, 3, 1, 3, 1);
    run_steps(1, 4, 10, 4, 1);

    for (int k = 0; k < 8; k++)
      run_steps(int'($urandom_range(0, 6)), int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));

    // Abort in the 3rd cycle of the second phase-1 request of a 4-step run.
    do_reset();
    cfg_d1 = 5; cfg_h1 = 1; cfg_d2 = 5; cfg_h2 = 1;
    clear_logs();
    n_steps = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && seq_q.size() < 3; i++) step();
    check_eq("abort_reach_p1", seq_q.size(), 3);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_p1_ready", int'(p1_ready), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_step_count", int'(step_count), 1);
    check_eq("abort_db", int'(double_buffer), 1);
    repeat (10) step();
    check_eq("abort_no_done", done_q.size(), 0);
    check_eq("abort_no_ready", seq_q.size(), 3);

    // Start and abort together from IDLE: the run must not begin.
    clear_logs();
    n_steps = 16'd2;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_eq("prio_busy", int'(busy), 0);
    check_eq("prio_p1_ready", int'(p1_ready), 0);
    repeat (5) step();
    check_eq("prio_no_ready", seq_q.size(), 0);

    // Asynchronous reset in the middle of a phase-2 request.
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (p2_ready) seen = 1;
      else step();
    end
    check_eq("rst_reach_p2", int'(seen), 1);
    step();
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_reset_outputs", outs_packed(), 0);
    step();
    reset = 1'b0;
    step();
    check_eq("post_reset_outputs", outs_packed(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_phase_sequencer.md
Name: md_phase_sequencer

Overview:
- Initiator end of the phase CTL handshake: issues READY to the force phase (phase 1) and the motion-update phase (phase 2), and consumes their DONE.
- Owns the position/velocity double-buffer select, counting completed timesteps up to a programmed total.
- Top-level controller between the host/start logic and the phase engines.
- Includes a per-phase watchdog and abort.

Parameters:
- STEP_W, 16, width of the timestep count and counter.
- TIMEOUT, 1048576, max clk cycles spent in any single handshake state before error; 0 disables the watchdog.
- TO_W, 21, watchdog counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  sequencer clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to run n_steps timesteps; honoured only in IDLE or ERROR.
- abort  in  1  level; forces return to IDLE.
- n_steps  in  STEP_W  timesteps to run; sampled on the accepted start.
- p1_ready  out  1  READY to phase 1 (level).
- p1_done  in  1  DONE from phase 1 (level).
- p2_ready  out  1  READY to phase 2 (level).
- p2_done  in  1  DONE from phase 2 (level).
- double_buffer  out  1  buffer select shared by both phases.
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle pulse when all steps complete.
- step_count  out  STEP_W  timesteps completed in the current run.
- timeout_err  out  1  sticky watchdog error flag.
- err_phase  out  2  phase that timed out: 1 = phase 1, 2 = phase 2; 0 = none.

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog counter 0, latched step target 0.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, P1_REQ, P1_REL, P2_REQ, P2_REL, SWAP, FINISH, ERROR.
- IDLE/ERROR + start, n_steps != 0:
  - latch n_steps; clear step_count, timeout_err and err_phase;
  - next state P1_REQ; p1_ready is high in the cycle after start is sampled.
- IDLE/ERROR + start, n_steps == 0: go to FINISH. done pulses one cycle later; no READY is issued.
- P1_REQ: p1_ready held high. When p1_done is sampled high: p1_ready low next cycle, go to P1_REL.
- P1_REL: wait for p1_done low, then go to P2_REQ (p2_ready high the next cycle). Phase 1 and phase 2 READY are never high together.
- P2_REQ / P2_REL: mirror P1_REQ / P1_REL on p2_ready and p2_done; P2_REL exits to SWAP.
- SWAP (exactly 1 cycle):
  - toggle double_buffer; step_count += 1;
  - if the new step_count equals the target, go to FINISH; else go to P1_REQ.
- FINISH (1 cycle): done = 1, then IDLE. double_buffer keeps its value across runs and is cleared only by reset.
- Watchdog:
  - counter clears on every state change and increments each cycle spent in P1_REQ, P1_REL, P2_REQ or P2_REL.
  - When the counter reaches TIMEOUT: go to ERROR, drop both READYs next cycle, set timeout_err = 1 and err_phase.
  - ERROR holds until start or reset.
- DONE already high on READY rise (stale DONE): accepted as completion. Phase engines must drop DONE while READY is low, and the REL states enforce that.
- abort (any state except IDLE):
  - next state IDLE; READYs low next cycle; done not pulsed;
  - step_count and double_buffer hold; abort has priority over all other transitions.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- step_count is STEP_W bits, counts up to n_steps and never wraps, since n_steps <= 2^STEP_W - 1.
- Reset mid-run: immediate return to reset values, including double_buffer = 0.

Test Plan:
- Nominal run:
  - stimulus: start with n_steps = 3; each engine asserts DONE 5 cycles after READY and drops it 1 cycle after READY falls.
  - required: READY order p1, p2, p1, p2, p1, p2; double_buffer sequence 0→1→0→1; step_count ends at 3; exactly one done pulse; busy low the cycle after done.
- Zero steps:
  - stimulus: start with n_steps = 0.
  - required: done pulses exactly 2 cycles after start; no READY; step_count = 0; double_buffer unchanged.
- Watchdog:
  - stimulus: TIMEOUT = 16; phase 2 never asserts DONE.
  - required: 16 cycles after p2_ready rises, state ERROR; p2_ready low; timeout_err = 1; err_phase = 2; busy = 0. A following start with n_steps = 1 clears the error and completes.
- Stale DONE:
  - stimulus: p1_done held high for 10 cycles after p1_ready falls.
  - required: p2_ready stays low until 1 cycle after p1_done falls.
- Abort:
  - stimulus: abort asserted in the 3rd cycle of the second P1_REQ during an n_steps = 4 run.
  - required: p1_ready low next cycle; state IDLE; no done pulse; step_count = 1; double_buffer = 1.
- Priority and reset:
  - stimulus: start and abort in the same cycle from IDLE; then async reset asserted mid P2_REQ.
  - required: the run does not start; on reset, all outputs are 0 immediately, with no clock edge needed.
